mmio_multi_timer: RTL and testbench
===================================

Name: mmio_multi_timer

Overview:
- Memory-mapped, multi-channel interval timer for the processor's I/O bus. It is decoded alongside the HEX, LEDR, KEY and SW devices.
- All channels share one prescaler. Each channel has its own count, limit and control/status registers, with sticky ready/overrun flags and per-channel interrupt enable.
- Read data is combinational, so it feeds the memout mux in the memory stage. Writes commit on the next clock edge.

Parameters:
- DBITS, 32, data and address width.
- BASE, 32'hFFFFF100, base byte address; must be 16-byte aligned.
- NCH, 2, number of channels (1..16).
- PRESCALE, 50000, clk cycles per count tick (>=1); 1 ms at 50 MHz.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  DBITS  byte address from the memory stage.
- wdata  in  DBITS  write data.
- we  in  1  write strobe, qualified internally by address hit.
- sel  out  1  addr falls inside this device's window (combinational).
- rdata  out  DBITS  read data; 0 when sel=0 (combinational).
- irq_vec  out  NCH  per-channel interrupt, ready & ie (registered state).
- irq  out  1  OR of irq_vec.

Behaviour:
- Clock and reset: clock clk. Reset reset is asynchronous, active-high. Reset clears the prescaler and every CNT, LIM and CTL register to 0. All outputs derived from state are 0 after reset. Reset mid-count loses all state, with no partial effects.
- Address map:
  - Channel c occupies BASE+16*c.
  - Offset 0 is CNT (RW), 4 is LIM (RW), 8 is CTL (RW), C is reserved (reads 0, writes ignored).
  - sel = (addr >= BASE) && (addr < BASE+16*NCH) && addr[1:0]==0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 for exactly one cycle when it equals PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- Channel update on tick:
  - If LIM!=0 and CNT==LIM-1: CNT<=0. If ready was already 1, set overrun, else set ready.
  - Otherwise CNT<=CNT+1, wrapping modulo 2^DBITS.
  - LIM==0 means free-running; no ready/overrun events.
- CTL bits:
  - bit0 ready: sticky.
  - bit1 overrun: sticky.
  - bit4 ie: RW.
  - Other bits read 0.
  - Writing 0 to bit0 or bit1 clears it; writing 1 has no effect.
- Writes:
  - CNT write loads wdata.
  - LIM write loads wdata and clears CNT to 0.
  - CTL write updates ie and clears flags as above.
- Simultaneous events:
  - A CNT or LIM write in the same cycle as a tick wins over the increment; no limit event is generated that cycle.
  - A CTL clear in the same cycle as a limit hit: the set wins. If ready is cleared and the hit occurs together, ready ends at 1 and overrun is unchanged.
- Latency:
  - A register write is visible on rdata the cycle after the we edge.
  - irq_vec follows the ready/ie state with no extra register stage.

Optional Feature:
- Macro: TIMER_ONESHOT_EN.
- With the macro:
  - CTL bit5 is oneshot (RW) and bit6 is stopped (RO).
  - On a limit hit with oneshot=1, CNT<=0 and stopped<=1. A stopped channel ignores ticks.
  - A write to CNT or LIM clears stopped.
- Without the macro: bits 5 and 6 read 0, writes to them are ignored, and all channels are periodic.

Decomposition:
- Shared package timer_pkg holds:
  - register offsets: OFF_CNT=0, OFF_LIM=4, OFF_CTL=8.
  - channel stride: 16.
  - CTL bit indices: READY=0, OVR=1, IE=4, ONESHOT=5, STOPPED=6.
- Sub-module timer_channel (one instance per channel, via generate) holds CNT, LIM and CTL. Its inputs are tick, per-register write strobes and wdata; its outputs are the three register values and irq.
- The top level holds the prescaler, address decode and read mux.

Test Plan (NCH=2, PRESCALE=4, BASE=32'hFFFFF100):
- Reset, then read 0xFFFFF100 / 0xFFFFF104 / 0xFFFFF108 -> all 0, sel=1, irq=0. Read 0xFFFFF120 -> sel=0, rdata=0.
- Write LIM0=3 -> after 12 clk cycles CNT0 wraps 2->0 and CTL0 reads 0x1. CNT1 (LIM1=0) keeps incrementing, CTL1=0.
- With ready0 uncleared, wait 12 more cycles -> CTL0=0x3. Then write CTL0=0x10 -> reads 0x10, irq=0. At the next hit -> irq_vec=2'b01, irq=1. Write CTL0=0x10 -> irq=0 the next cycle.
- Write CTL0=0x10 on the exact cycle of a limit hit -> CTL0 reads 0x11 and irq stays 1.
- Write CNT1=32'hFFFFFFFF -> after one tick CNT1=0 and CTL1=0. A CNT1 write coinciding with tick -> CNT1 equals the written value.
- With TIMER_ONESHOT_EN: write CTL0=0x20, LIM0=2 -> after 8 cycles CTL0=0x61 and CNT0 stays 0 for 20+ cycles. Write CNT0=0 -> counting resumes.

Source files
------------

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped multi-channel interval timer:
// register offsets within a channel window, the channel stride, and the bit
// positions of the CTL register fields.
// -----------------------------------------------------------------------------
package timer_pkg;

  // Byte offset of each register inside a 16-byte channel window.
  typedef enum logic [3:0] {
    OFF_CNT = 4'h0,
    OFF_LIM = 4'h4,
    OFF_CTL = 4'h8,
    OFF_RSV = 4'hC
  } reg_off_e;

  localparam int CH_STRIDE = 16;

  // CTL field bit positions.
  localparam int READY   = 0;
  localparam int OVR     = 1;
  localparam int IE      = 4;
  localparam int ONESHOT = 5;
  localparam int STOPPED = 6;

endpackage

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One timer channel: CNT, LIM and CTL registers plus the limit-hit logic.
//
// Build option: TIMER_ONESHOT_EN adds CTL.oneshot (RW) and CTL.stopped (RO).
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   i_tick     shared prescaler tick (one cycle wide)
//   i_we_cnt   write strobe for CNT
//   i_we_lim   write strobe for LIM (also clears CNT)
//   i_we_ctl   write strobe for CTL
//   i_wdata    write data
//   o_cnt      current CNT value
//   o_lim      current LIM value
//   o_ctl      assembled CTL value (unused bits read 0)
//   o_irq      ready & ie
// -----------------------------------------------------------------------------
module timer_channel
  import timer_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_we_cnt,
  input  logic             i_we_lim,
  input  logic             i_we_ctl,
  input  logic [DBITS-1:0] i_wdata,
  output logic [DBITS-1:0] o_cnt,
  output logic [DBITS-1:0] o_lim,
  output logic [DBITS-1:0] o_ctl,
  output logic             o_irq
);

  logic [DBITS-1:0] r_cnt;
  logic [DBITS-1:0] r_lim;
  logic             r_ready;
  logic             r_ovr;
  logic             r_ie;

  logic [DBITS-1:0] w_lim_m1;
  logic             w_stopped;
  logic             w_reg_write;
  logic             w_hit;

  assign w_lim_m1    = r_lim - DBITS'(1);
  assign w_reg_write = i_we_cnt | i_we_lim;

  // A CNT/LIM write in the tick cycle takes priority, so it also suppresses
  // the limit event for that cycle.
  assign w_hit = i_tick && !w_stopped && (r_lim != '0) && (r_cnt == w_lim_m1)
                 && !w_reg_write;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_lim <= '0;
    end else begin
      if (i_we_cnt)                 r_cnt <= i_wdata;
      else if (i_we_lim)            r_cnt <= '0;
      else if (w_hit)               r_cnt <= '0;
      else if (i_tick && !w_stopped) r_cnt <= r_cnt + DBITS'(1);

      if (i_we_lim) r_lim <= i_wdata;
    end
  end

  // Flags are sticky; software clears by writing 0. A hit in the same cycle
  // as a clear wins, and overrun is judged against the pre-edge ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
      r_ie    <= 1'b0;
    end else begin
      if (w_hit)                           r_ready <= 1'b1;
      else if (i_we_ctl && !i_wdata[READY]) r_ready <= 1'b0;

      if (w_hit && r_ready)                r_ovr <= 1'b1;
      else if (i_we_ctl && !i_wdata[OVR])  r_ovr <= 1'b0;

      if (i_we_ctl) r_ie <= i_wdata[IE];
    end
  end

`ifdef TIMER_ONESHOT_EN
  logic r_oneshot;
  logic r_stopped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oneshot <= 1'b0;
      r_stopped <= 1'b0;
    end else begin
      if (i_we_ctl) r_oneshot <= i_wdata[ONESHOT];

      if (w_reg_write)            r_stopped <= 1'b0;
      else if (w_hit && r_oneshot) r_stopped <= 1'b1;
    end
  end

  assign w_stopped = r_stopped;
`else
  assign w_stopped = 1'b0;
`endif

  // NOTE: o_ctl is cleared first so every path through the block assigns it
  // and no latch is inferred for the unused bits.
  always_comb begin
    o_ctl        = '0;
    o_ctl[READY] = r_ready;
    o_ctl[OVR]   = r_ovr;
    o_ctl[IE]    = r_ie;
`ifdef TIMER_ONESHOT_EN
    o_ctl[ONESHOT] = r_oneshot;
    o_ctl[STOPPED] = r_stopped;
`endif
  end

  assign o_cnt = r_cnt;
  assign o_lim = r_lim;
  assign o_irq = r_ready & r_ie;

endmodule

// File: rtl/mmio_multi_timer.sv
// -----------------------------------------------------------------------------
// mmio_multi_timer
// Memory-mapped multi-channel interval timer on the processor I/O bus.
// One shared prescaler drives NCH timer_channel instances. Channel c lives at
// BASE + 16*c with CNT at +0, LIM at +4, CTL at +8 and +C reserved.
// Read data is combinational; writes commit on the next clock edge.
//
// Build option: TIMER_ONESHOT_EN (passed through to timer_channel).
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   addr     byte address from the memory stage
//   wdata    write data
//   we       write strobe (qualified by sel)
//   sel      addr is a word address inside this device's window
//   rdata    read data, 0 when sel=0
//   irq_vec  per-channel ready & ie
//   irq      OR of irq_vec
// -----------------------------------------------------------------------------
module mmio_multi_timer
  import timer_pkg::*;
#(
  parameter int                 DBITS    = 32,
  parameter logic [DBITS-1:0]   BASE     = 32'hFFFFF100,
  parameter int                 NCH      = 2,
  parameter int                 PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  output logic             sel,
  output logic [DBITS-1:0] rdata,
  output logic [NCH-1:0]   irq_vec,
  output logic             irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // One bit wider than the bus so BASE + window never wraps in the compare.
  localparam logic [DBITS:0] END_ADDR = {1'b0, BASE} + (DBITS+1)'(CH_STRIDE * NCH);

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [7:0] w_rel;  // offset from BASE; the window is at most 256 bytes
  logic [3:0] w_ch;
  logic [3:0] w_off;

  assign sel   = (addr >= BASE) && ({1'b0, addr} < END_ADDR) && (addr[1:0] == 2'b00);
  assign w_rel = addr[7:0] - BASE[7:0];
  assign w_ch  = w_rel[7:4];
  assign w_off = w_rel[3:0];

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  logic [DBITS-1:0] w_cnt [NCH];
  logic [DBITS-1:0] w_lim [NCH];
  logic [DBITS-1:0] w_ctl [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic w_ch_hit;

    assign w_ch_hit = we && sel && (w_ch == 4'(c));

    timer_channel #(
      .DBITS (DBITS)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .i_tick   (w_tick),
      .i_we_cnt (w_ch_hit && (w_off == OFF_CNT)),
      .i_we_lim (w_ch_hit && (w_off == OFF_LIM)),
      .i_we_ctl (w_ch_hit && (w_off == OFF_CTL)),
      .i_wdata  (wdata),
      .o_cnt    (w_cnt[c]),
      .o_lim    (w_lim[c]),
      .o_ctl    (w_ctl[c]),
      .o_irq    (irq_vec[c])
    );
  end

  assign irq = |irq_vec;

  // ---------------------------------------------------------------------------
  // Read mux (reserved offset reads 0)
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (sel) begin
      for (int c = 0; c < NCH; c++) begin
        if (w_ch == 4'(c)) begin
          if (w_off == OFF_CNT)      rdata = w_cnt[c];
          else if (w_off == OFF_LIM) rdata = w_lim[c];
          else if (w_off == OFF_CTL) rdata = w_ctl[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_mmio_multi_timer
// Directed bench for mmio_multi_timer (NCH=2, PRESCALE=4). Stimulus runs on a
// slot grid: slot k is the interval after the k-th rising edge following reset
// release, so the prescaler ticks in slots 3,7,11,... and channel state
// changes at edges 4,8,12,... A write driven in slot k is visible in slot k+1.
// Expected values are queued with each probe; a monitor samples on the
// falling edge and compares.
// -----------------------------------------------------------------------------
module tb_mmio_multi_timer;

  localparam logic [31:0] BASE = 32'hFFFFF100;
  localparam logic [31:0] CNT0 = BASE + 32'h00;
  localparam logic [31:0] LIM0 = BASE + 32'h04;
  localparam logic [31:0] CTL0 = BASE + 32'h08;
  localparam logic [31:0] CNT1 = BASE + 32'h10;
  localparam logic [31:0] LIM1 = BASE + 32'h14;
  localparam logic [31:0] CTL1 = BASE + 32'h18;
  localparam logic [31:0] RSV1 = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        sel;
  logic [31:0] rdata;
  logic [1:0]  irq_vec;
  logic        irq;

  mmio_multi_timer #(
    .DBITS    (32),
    .BASE     (BASE),
    .NCH      (2),
    .PRESCALE (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .sel     (sel),
    .rdata   (rdata),
    .irq_vec (irq_vec),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RDATA, K_SEL, K_IRQ, K_IRQV} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic probe    = 1'b0;
  int   cur_slot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: consumes every expectation queued for the current probe slot.
  always @(negedge clk) begin
    if (probe) begin
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.kind)
          K_RDATA: act = rdata;
          K_SEL:   act = {31'b0, sel};
          K_IRQ:   act = {31'b0, irq};
          default: act = {30'b0, irq_vec};
        endcase
        check(e.name, act, e.val);
      end
    end
  end

  // Advance to slot k; the bus returns to idle after every edge.
  task automatic go(input int k);
    while (cur_slot < k) begin
      @(posedge clk);
      #1;
      we    = 1'b0;
      probe = 1'b0;
      cur_slot++;
    end
  endtask

  task automatic rd(input logic [31:0] a);
    addr  = a;
    probe = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
  endtask

  task automatic exp_push(input string name, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    we    = 1'b0;
    probe = 1'b0;
    reset = 1'b1;
    #12;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cur_slot = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // ---------------- reset state ----------------
    do_reset();
    rd(CNT0); exp_push("rst_cnt0", K_RDATA, 32'h0); exp_push("rst_sel", K_SEL, 32'h1);
              exp_push("rst_irq", K_IRQ, 32'h0);
    go(1); rd(LIM0); exp_push("rst_lim0", K_RDATA, 32'h0);
    go(2); rd(CTL0); exp_push("rst_ctl0", K_RDATA, 32'h0); exp_push("rst_irqv", K_IRQV, 32'h0);
    go(3); rd(BASE + 32'h20); exp_push("out_sel", K_SEL, 32'h0);
                              exp_push("out_rdata", K_RDATA, 32'h0);

    // ---------------- periodic limit, flags, irq ----------------
    do_reset();
    wr(LIM0, 32'd3);
    go(11); rd(CNT0); exp_push("cnt0_pre_wrap", K_RDATA, 32'd2);
    go(12); rd(CNT0); exp_push("cnt0_wrap", K_RDATA, 32'd0);
    go(13); rd(CTL0); exp_push("ctl0_ready", K_RDATA, 32'h1);
    go(14); rd(CNT1); exp_push("cnt1_free", K_RDATA, 32'd3);
    go(15); rd(CTL1); exp_push("ctl1_free", K_RDATA, 32'h0);
    go(24); rd(CTL0); exp_push("ctl0_ovr", K_RDATA, 32'h3); exp_push("irq_ie0", K_IRQ, 32'h0);
    go(25); rd(CNT1); exp_push("cnt1_six", K_RDATA, 32'd6);
    go(26); wr(CTL0, 32'h10);
    go(27); rd(CTL0); exp_push("ctl0_ie", K_RDATA, 32'h10); exp_push("irq_clr", K_IRQ, 32'h0);
    go(36); rd(CTL0); exp_push("ctl0_hit_ie", K_RDATA, 32'h11);
                      exp_push("irqv_hit", K_IRQV, 32'h1); exp_push("irq_hit", K_IRQ, 32'h1);
            wr(CTL0, 32'h10);
    go(37); rd(CTL0); exp_push("ctl0_ack", K_RDATA, 32'h10); exp_push("irq_ack", K_IRQ, 32'h0);
    go(47); wr(CTL0, 32'h10);  // clear lands on the limit-hit edge
    go(48); rd(CTL0); exp_push("ctl0_set_wins", K_RDATA, 32'h11);
                      exp_push("irq_set_wins", K_IRQ, 32'h1);

    // ---------------- wrap, write/tick priority, decode ----------------
    go(49); wr(CNT1, 32'hFFFF_FFFF);
    go(50); rd(CNT1); exp_push("cnt1_loaded", K_RDATA, 32'hFFFF_FFFF);
    go(52); rd(CNT1); exp_push("cnt1_wrap", K_RDATA, 32'h0);
    go(53); rd(CTL1); exp_push("ctl1_no_evt", K_RDATA, 32'h0);
    go(55); wr(CNT1, 32'h1234);  // coincides with tick
    go(56); rd(CNT1); exp_push("cnt1_wr_wins", K_RDATA, 32'h1234);
    go(60); rd(CNT1); exp_push("cnt1_inc", K_RDATA, 32'h1235);
    go(61); wr(RSV1, 32'hFFFF_FFFF);
    go(62); rd(RSV1); exp_push("rsv_rdata", K_RDATA, 32'h0); exp_push("rsv_sel", K_SEL, 32'h1);
    go(63); rd(BASE + 32'h1); exp_push("misalign_sel", K_SEL, 32'h0);
                              exp_push("misalign_rdata", K_RDATA, 32'h0);
    go(64); wr(LIM1, 32'd5);
    go(65); rd(CNT1); exp_push("lim1_clr_cnt", K_RDATA, 32'h0);
    go(66); rd(LIM1); exp_push("lim1_val", K_RDATA, 32'd5);

`ifdef TIMER_ONESHOT_EN
    // ---------------- one-shot ----------------
    do_reset();
    rd(CNT1); exp_push("rst2_cnt1", K_RDATA, 32'h0); exp_push("rst2_irq", K_IRQ, 32'h0);
    go(1); wr(CTL0, 32'h20);
    go(2); wr(LIM0, 32'd2);
    go(8);  rd(CTL0); exp_push("os_stop", K_RDATA, 32'h61);
    go(20); rd(CTL0); exp_push("os_hold_ctl", K_RDATA, 32'h61);
    go(30); rd(CNT0); exp_push("os_hold_cnt", K_RDATA, 32'h0);
    go(31); wr(CNT0, 32'h0);
    go(32); rd(CTL0); exp_push("os_restart", K_RDATA, 32'h21);
    go(36); rd(CNT0); exp_push("os_count", K_RDATA, 32'd1);
    go(40); rd(CTL0); exp_push("os_second", K_RDATA, 32'h63);
    go(41);
`else
    // ---------------- bits 5/6 absent ----------------
    do_reset();
    rd(CNT1); exp_push("rst2_cnt1", K_RDATA, 32'h0); exp_push("rst2_irq", K_IRQ, 32'h0);
    go(1); wr(CTL1, 32'h7F);
    go(2); rd(CTL1); exp_push("ctl1_mask", K_RDATA, 32'h10);
    go(3);
`endif

    go(cur_slot + 2);
    check("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
